// File: rtl/dm_access_unit.sv
// Data-memory access unit: turns one pipeline load/store into a registered single-port SRAM access.
// Optional macro DM_MISALIGN_TRAP_EN flags misaligned half/word accesses instead of aligning them.
module dm_access_unit #(
  parameter int unsigned AW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] A_dm,
  output logic [31:0]   DI_dm,
  output logic          OE_dm,
  output logic [3:0]    WEB_dm,
  input  logic [31:0]   DO_dm
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [1:0]      lane_q, lane_d;
  logic            err_q, err_d;
  logic [AW-1:0]   a_dm_q, a_dm_d;
  logic [31:0]     di_dm_q, di_dm_d;
  logic            oe_dm_q, oe_dm_d;
  logic [3:0]      web_dm_q, web_dm_d;

  logic            is_byte, is_half;
  logic            req_err;
  logic [1:0]      lane_al;
  logic [3:0]      web_st;
  logic [31:0]     di_st;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic            unused_addr;

  assign unused_addr = ^req_addr[31:AW+2];

  assign is_byte = (req_size == 2'b00);
  assign is_half = (req_size == 2'b01);

`ifdef DM_MISALIGN_TRAP_EN
  assign req_err = (is_half & req_addr[0]) | (!is_byte & !is_half & (|req_addr[1:0]));
  assign lane_al = req_addr[1:0];
`else
  assign req_err = 1'b0;
  assign lane_al = is_byte ? req_addr[1:0] : (is_half ? {req_addr[1], 1'b0} : 2'b00);
`endif

  // Store lane enables (active-low) and replicated data, from the aligned lane.
  always_comb begin
    if (is_byte) begin
      web_st = ~(4'b0001 << lane_al);
      di_st  = {4{req_wdata[7:0]}};
    end else if (is_half) begin
      web_st = lane_al[1] ? 4'b0011 : 4'b1100;
      di_st  = {2{req_wdata[15:0]}};
    end else begin
      web_st = 4'b0000;
      di_st  = req_wdata;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    lane_d   = lane_q;
    err_d    = err_q;
    a_dm_d   = a_dm_q;
    di_dm_d  = di_dm_q;
    oe_dm_d  = 1'b0;
    web_dm_d = 4'hF;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StAccess;
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          lane_d  = lane_al;
          err_d   = req_err;
          a_dm_d  = req_addr[AW+1:2];
          if (!req_err) begin
            if (req_we) begin
              web_dm_d = web_st;
              di_dm_d  = di_st;
            end else begin
              oe_dm_d = 1'b1;
            end
          end
        end
      end
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      lane_q   <= 2'b00;
      err_q    <= 1'b0;
      a_dm_q   <= '0;
      di_dm_q  <= 32'h0;
      oe_dm_q  <= 1'b0;
      web_dm_q <= 4'hF;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      lane_q   <= lane_d;
      err_q    <= err_d;
      a_dm_q   <= a_dm_d;
      di_dm_q  <= di_dm_d;
      oe_dm_q  <= oe_dm_d;
      web_dm_q <= web_dm_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_err   = (state_q == StResp) & err_q;
  assign A_dm      = a_dm_q;
  assign DI_dm     = di_dm_q;
  assign OE_dm     = oe_dm_q;
  assign WEB_dm    = web_dm_q;

  // SRAM data arrives during RESP, so load extraction is combinational on DO_dm.
  assign byte_v = DO_dm[{lane_q, 3'b000} +: 8];
  assign half_v = lane_q[1] ? DO_dm[31:16] : DO_dm[15:0];

  always_comb begin
    rsp_rdata = 32'h0;
    if ((state_q == StResp) && !we_q && !err_q) begin
      case (size_q)
        2'b00:   rsp_rdata = {{24{~uns_q & byte_v[7]}}, byte_v};
        2'b01:   rsp_rdata = {{16{~uns_q & half_v[15]}}, half_v};
        default: rsp_rdata = DO_dm;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit with a behavioural single-port SRAM model.
// Expectations for misaligned word loads follow DM_MISALIGN_TRAP_EN.
module tb_dm_access_unit;

  localparam int unsigned AW = 14;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] A_dm;
  logic [31:0]   DI_dm;
  logic          OE_dm;
  logic [3:0]    WEB_dm;
  logic [31:0]   DO_dm;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:(1<<AW)-1];

  logic [31:0] s_oe, s_web, s_a, s_di, s_rv, s_rd, s_re;
  int          acc_cnt;
  logic [8:0]  rv_mask;

  dm_access_unit #(.AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .A_dm         (A_dm),
    .DI_dm        (DI_dm),
    .OE_dm        (OE_dm),
    .WEB_dm       (WEB_dm),
    .DO_dm        (DO_dm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (OE_dm) DO_dm <= mem[A_dm];
    for (int i = 0; i < 4; i++) begin
      if (!WEB_dm[i]) mem[A_dm][8*i +: 8] <= DI_dm[8*i +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request; captures SRAM outputs in ACCESS and response fields in RESP.
  task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    check("ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    s_oe  = {31'b0, OE_dm};
    s_web = {28'b0, WEB_dm};
    s_a   = {{(32-AW){1'b0}}, A_dm};
    s_di  = DI_dm;
    check("no_rsp_in_access", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    s_rv = {31'b0, rsp_valid};
    s_rd = rsp_rdata;
    s_re = {31'b0, rsp_err};
    check("sram_idle_in_resp", {27'b0, OE_dm, WEB_dm}, 32'h0000000F);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    DO_dm        = 32'h0;
    rst          = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;

    repeat (2) @(negedge clk);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
    check("rst_rsp_rdata", rsp_rdata,          32'h0);
    check("rst_oe",        {31'b0, OE_dm},     32'd0);
    check("rst_web",       {28'b0, WEB_dm},    32'hF);
    check("rst_a",         {18'b0, A_dm},      32'h0);
    check("rst_di",        DI_dm,              32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);

    // Word store
    xact(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1234_5678);
    check("sw_oe",    s_oe,  32'd0);
    check("sw_a",     s_a,   32'd4);
    check("sw_web",   s_web, 32'h0);
    check("sw_di",    s_di,  32'h1234_5678);
    check("sw_rv",    s_rv,  32'd1);
    check("sw_rdata", s_rd,  32'h0);
    check("sw_err",   s_re,  32'd0);

    // Byte store lane 3, then byte loads signed/unsigned
    xact(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00AB);
    check("sb_web", s_web, 32'h7);
    check("sb_di",  s_di,  32'hABAB_ABAB);
    xact(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0);
    check("lb_oe",    s_oe,  32'd1);
    check("lb_web",   s_web, 32'hF);
    check("lb_a",     s_a,   32'd4);
    check("lb_rdata", s_rd,  32'hFFFF_FFAB);
    xact(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0);
    check("lbu_rdata", s_rd, 32'h0000_00AB);
    xact(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
    check("lw_merged", s_rd, 32'hAB34_5678);

    // Half loads from 0x8001_7FFF
    xact(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h8001_7FFF);
    xact(1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0);
    check("lh_hi", s_rd, 32'hFFFF_8001);
    xact(1'b0, 2'b01, 1'b0, 32'h0000_0020, 32'h0);
    check("lh_lo", s_rd, 32'h0000_7FFF);
    xact(1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0);
    check("lhu_hi", s_rd, 32'h0000_8001);
    xact(1'b0, 2'b00, 1'b1, 32'h0000_0021, 32'h0);
    check("lbu_l1", s_rd, 32'h0000_007F);
    xact(1'b0, 2'b00, 1'b0, 32'h0000_0020, 32'h0);
    check("lb_l0", s_rd, 32'hFFFF_FFFF);

    // Half store upper lane
    xact(1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h1234_BEEF);
    check("sh_web", s_web, 32'h3);
    check("sh_di",  s_di,  32'hBEEF_BEEF);
    xact(1'b0, 2'b11, 1'b0, 32'h0000_0020, 32'h0);
    check("lw_after_sh", s_rd, 32'hBEEF_7FFF);

    // Misaligned word load
    xact(1'b0, 2'b10, 1'b0, 32'h0000_0022, 32'h0);
    check("mis_rv", s_rv, 32'd1);
`ifdef DM_MISALIGN_TRAP_EN
    check("mis_oe",    s_oe, 32'd0);
    check("mis_err",   s_re, 32'd1);
    check("mis_rdata", s_rd, 32'h0);
`else
    check("mis_oe",    s_oe, 32'd1);
    check("mis_a",     s_a,  32'd8);
    check("mis_err",   s_re, 32'd0);
    check("mis_rdata", s_rd, 32'hBEEF_7FFF);
`endif

    // Reset during ACCESS of a word store aborts the write
    xact(1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h1111_1111);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h0000_0040;
    req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("abort_web_pre", {28'b0, WEB_dm}, 32'h0);
    rst = 1'b0;
    #1;
    check("abort_web", {28'b0, WEB_dm}, 32'hF);
    check("abort_oe",  {31'b0, OE_dm},  32'd0);
    repeat (2) begin
      @(negedge clk);
      check("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    rst = 1'b1;
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    check("abort_no_rsp_post", {31'b0, rsp_valid}, 32'd0);
    xact(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
    check("abort_mem", s_rd, 32'h1111_1111);

    // req_valid held for 9 cycles
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'b10;
    req_addr  = 32'h0000_0010;
    acc_cnt   = 0;
    rv_mask   = 9'b0;
    for (int k = 0; k < 9; k++) begin
      if (req_ready) acc_cnt++;
      rv_mask[k] = rsp_valid;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_accepts", acc_cnt, 32'd3);
    check("b2b_rsp_cyc", {23'b0, rv_mask}, 32'h124);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dm_access_unit.md
DM_ACCESS_UNIT -- requirements
Module: dm_access_unit

Interface
REQ-001 SHALL have parameter AW, default 14, the data-SRAM word-address width (A_dm = req_addr[AW+1:2]).
REQ-002 SHALL have one clock and an asynchronous, active-low reset; ports clk and rst.
REQ-003 clk  input  1  rising-edge clock, shared with data SRAM.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  pipeline memory request present.
REQ-006 req_ready  output  1  unit can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word, 11 decoded as word.
REQ-009 req_unsigned  input  1  zero-extend load result when 1.
REQ-010 req_addr  input  32  byte address; bits above AW+1 ignored.
REQ-011 req_wdata  input  32  store data, LSB-aligned.
REQ-012 rsp_valid  output  1  one-cycle completion pulse.
REQ-013 rsp_rdata  output  32  extended load data; 0 for stores/errors.
REQ-014 rsp_err  output  1  misaligned-access flag, valid with rsp_valid.
REQ-015 A_dm  output  AW  data SRAM word address.
REQ-016 DI_dm  output  32  data SRAM write data.
REQ-017 OE_dm  output  1  data SRAM read enable.
REQ-018 WEB_dm  output  4  data SRAM byte write enables, active-low.
REQ-019 DO_dm  input  32  data SRAM read data, valid the cycle after OE_dm sampled.

Function
REQ-020 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; req_ready=1 only in IDLE.
REQ-021 Accept on req_valid&&req_ready at cycle T; SHALL capture we/size/unsigned/addr/wdata in registers.
REQ-022 In ACCESS (T+1), all SRAM outputs SHALL be registered: load -> OE_dm=1, WEB_dm=4'hF; store -> OE_dm=0, WEB_dm per REQ-024.
REQ-023 In RESP (T+2), rsp_valid=1 for exactly one cycle, no backpressure; next request acceptable at T+3.
REQ-024 Store WEB_dm: byte ~(4'b0001<<addr[1:0]); half addr[1]?4'b0011:4'b1100; word 4'b0000.
REQ-025 Store DI_dm: byte replicated x4, half replicated x2, word as-is.
REQ-026 Load: byte lane addr[1:0], half lane addr[1], extracted from DO_dm in RESP, sign-extended unless unsigned.
REQ-027 Outside ACCESS: OE_dm=0, WEB_dm=4'hF; A_dm and DI_dm hold last value.
REQ-028 req_valid while not IDLE SHALL be ignored (no capture, no side effects).

Reset
REQ-029 rst low SHALL immediately force state IDLE, req_ready=1 after release, rsp_valid=0, rsp_err=0, rsp_rdata=0, OE_dm=0, WEB_dm=4'hF, A_dm=0, DI_dm=0.
REQ-030 Reset mid-ACCESS SHALL abort the write (WEB_dm=4'hF asynchronously) with no response issued.

Configuration
REQ-031 Macro DM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL pass ACCESS with OE_dm=0, WEB_dm=4'hF, then RESP with rsp_err=1, rsp_rdata=0.
REQ-032 Macro undefined: low address bits SHALL be forced aligned (half clears bit0, word clears bits1:0), access proceeds, rsp_err tied 0.

Verification
REQ-033 Store word 0x12345678 @0x0000_0010 -> T+1 A_dm=4, WEB_dm=0000, DI_dm=0x12345678; T+2 rsp_valid=1, rsp_rdata=0.
REQ-034 Store byte 0xAB @0x13 -> WEB_dm=0111, DI_dm=0xABABABAB; then load byte signed @0x13 -> rsp_rdata=0xFFFFFFAB; unsigned -> 0x000000AB.
REQ-035 Mem word 0x8001_7FFF @0x20, load half signed @0x22 -> 0xFFFF8001; @0x20 -> 0x00007FFF.
REQ-036 Load word @0x22: with DM_MISALIGN_TRAP_EN -> OE_dm stays 0, rsp_err=1, rsp_rdata=0; without -> reads word @0x20, rsp_err=0.
REQ-037 Assert rst low in ACCESS of a word store -> WEB_dm=4'hF same cycle, no rsp_valid, memory unchanged, req_ready=1 after release.
REQ-038 Hold req_valid high for 9 cycles with back-to-back requests -> exactly 3 accepted, rsp_valid at cycles 2, 5, 8.
